// File: rtl/sipo_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_rx_pkg
// Brief    : Shared types and constants for the sipo_rx serial-to-parallel
//            receiver (FSM state enum, default word width).
//            Optional feature macro: SIPO_RX_PARITY_EN
// Revision : 1.0 - initial release
// ============================================================================
package sipo_rx_pkg;

    // Default data word length in bits
    localparam int c_DEFAULT_WIDTH = 16;

    // Receiver FSM states; PARITY only exists when the parity bit is expected
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
`ifdef SIPO_RX_PARITY_EN
        ,
        ST_PARITY = 2'd2
`endif
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sipo_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : sipo_rx_if
// Brief    : Serial input / parallel output bundle for sipo_rx. The slave
//            modport is the receiver, the master modport is the environment
//            that supplies bits and consumes words.
//            Optional feature macro: SIPO_RX_PARITY_EN (adds parity_err)
// Revision : 1.0 - initial release
// ============================================================================
interface sipo_rx_if
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) ();

    logic             din;
    logic             bit_en;
    logic             sof;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overrun;
    logic             clr;
`ifdef SIPO_RX_PARITY_EN
    logic             parity_err;
`endif

    modport slave (
        input  din,
        input  bit_en,
        input  sof,
        input  dout_ready,
        input  clr,
        output dout,
        output dout_valid,
`ifdef SIPO_RX_PARITY_EN
        output parity_err,
`endif
        output overrun
    );

    modport master (
        output din,
        output bit_en,
        output sof,
        output dout_ready,
        output clr,
        input  dout,
        input  dout_valid,
`ifdef SIPO_RX_PARITY_EN
        input  parity_err,
`endif
        input  overrun
    );

endinterface
`default_nettype wire

// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
// Module   : sipo_rx
// Brief    : Serial-in parallel-out receiver. Frames start on sof, WIDTH
//            qualified bits are assembled (MSB or LSB first) and handed to a
//            single-entry valid/ready output register with a sticky overrun.
//            Optional feature macro: SIPO_RX_PARITY_EN (one even-parity bit
//            after the data, sticky parity_err).
// Revision : 1.0 - initial release
// ============================================================================
module sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH     = c_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    sipo_rx_if.slave  bus
);

    localparam int             CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  c_LAST_IDX = CW'(WIDTH - 1);
`ifdef SIPO_RX_PARITY_EN
    localparam logic [CW-1:0]  c_FULL     = CW'(WIDTH);
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_sr_nxt;
    logic [WIDTH-1:0] w_sr_shift;
    logic [WIDTH-1:0] w_sr_first;
    logic [WIDTH-1:0] w_word;
    logic             w_complete;

    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overrun;
`ifdef SIPO_RX_PARITY_EN
    logic             w_par_mismatch;
    logic             r_parity_err;
`endif

    // Bit order: the first bit of a frame must end up in dout[WIDTH-1]
    // (MSB first) or dout[0] (LSB first) after WIDTH shifts.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sr_shift = {r_sr[WIDTH-2:0], bus.din};
            assign w_sr_first = {{(WIDTH-1){1'b0}}, bus.din};
        end else begin : g_lsb_first
            assign w_sr_shift = {bus.din, r_sr[WIDTH-1:1]};
            assign w_sr_first = {bus.din, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    // Next-state, counter and shift-register update; sof always restarts
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_sr_nxt       = r_sr;
        w_word         = r_sr;
        w_complete     = 1'b0;
`ifdef SIPO_RX_PARITY_EN
        w_par_mismatch = 1'b0;
`endif
        if (bus.bit_en) begin
            if (bus.sof) begin
                w_state_nxt = ST_SHIFT;
                w_count_nxt = CW'(1);
                w_sr_nxt    = w_sr_first;
            end else begin
                case (r_state)
                    ST_SHIFT: begin
                        w_sr_nxt = w_sr_shift;
                        if (r_count == c_LAST_IDX) begin
`ifdef SIPO_RX_PARITY_EN
                            w_state_nxt = ST_PARITY;
                            w_count_nxt = c_FULL;
`else
                            w_state_nxt = ST_IDLE;
                            w_count_nxt = '0;
                            w_complete  = 1'b1;
                            w_word      = w_sr_shift;
`endif
                        end else begin
                            w_count_nxt = r_count + CW'(1);
                        end
                    end
`ifdef SIPO_RX_PARITY_EN
                    ST_PARITY: begin
                        // Even parity: data bits plus parity bit XOR to zero
                        w_state_nxt    = ST_IDLE;
                        w_count_nxt    = '0;
                        w_complete     = 1'b1;
                        w_word         = r_sr;
                        w_par_mismatch = ^{r_sr, bus.din};
                    end
`endif
                    default: begin
                        // IDLE: bits without sof are ignored
                    end
                endcase
            end
        end
    end

    // Frame state register: FSM state, bit counter, shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_sr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_sr    <= w_sr_nxt;
        end
    end

    // Output word register with valid/ready handoff and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            // clr loses against a new event on the same edge
            r_overrun    <= r_overrun & ~bus.clr;
`ifdef SIPO_RX_PARITY_EN
            r_parity_err <= r_parity_err & ~bus.clr;
`endif
            if (w_complete) begin
                if (!r_dout_valid || bus.dout_ready) begin
                    r_dout       <= w_word;
                    r_dout_valid <= 1'b1;
`ifdef SIPO_RX_PARITY_EN
                    if (w_par_mismatch) begin
                        r_parity_err <= 1'b1;
                    end
`endif
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_dout_valid && bus.dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.overrun    = r_overrun;
`ifdef SIPO_RX_PARITY_EN
    assign bus.parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the data word length in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, meaning the first received bit lands in dout[WIDTH-1] (1) or in dout[0] (0).
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port din  input  1  serial data bit, sampled only when bit_en=1.
REQ-006 The block SHALL have port bit_en  input  1  qualifies din as a valid bit this cycle.
REQ-007 The block SHALL have port sof  input  1  start of frame, marks the din bit as the first bit of a word (valid only with bit_en=1).
REQ-008 The block SHALL have port dout  output  WIDTH  assembled parallel word.
REQ-009 The block SHALL have port dout_valid  output  1  dout holds an unconsumed word.
REQ-010 The block SHALL have port dout_ready  input  1  consumer accepts dout this cycle.
REQ-011 The block SHALL have port overrun  output  1  sticky flag, a completed word was dropped.
REQ-012 The block SHALL have port clr  input  1  synchronous clear of overrun (and parity_err when compiled in).

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and PARITY (PARITY exists only with the parity feature); bit counter width is $clog2(WIDTH+1).
REQ-014 In IDLE, bit_en=1 with sof=1 SHALL capture din as bit 0, set count=1 and enter SHIFT; bit_en=1 with sof=0 SHALL be ignored.
REQ-015 In SHIFT, each bit_en=1 SHALL shift din into the shift register and increment count; cycles with bit_en=0 SHALL hold all state.
REQ-016 In SHIFT or PARITY, sof=1 with bit_en=1 SHALL discard the partial word silently and restart as in REQ-014.
REQ-017 Without parity, the edge that samples bit WIDTH-1 SHALL complete the word and return to IDLE; dout and dout_valid update on that same edge (latency 0 cycles after the last bit edge).
REQ-018 On completion with dout_valid=0, or with dout_valid=1 and dout_ready=1 on the same edge, dout SHALL load the new word and dout_valid SHALL be 1.
REQ-019 On completion with dout_valid=1 and dout_ready=0, the new word SHALL be dropped, dout SHALL be unchanged and overrun SHALL be set to 1.
REQ-020 dout_valid=1 and dout_ready=1 with no completion SHALL clear dout_valid on that edge; dout SHALL hold its value.
REQ-021 overrun SHALL stay 1 until clr=1; clr and a new overrun on the same edge SHALL leave overrun=1.
REQ-022 The next word's sof SHALL be accepted on the cycle immediately after completion (back-to-back frames, no gap required).

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, count=0, shift register=0, dout=0, dout_valid=0, overrun=0 and parity_err=0.
REQ-024 Reset asserted mid-frame SHALL discard the partial word; after release the block SHALL wait for a new sof.

Configuration
REQ-025 Macro SIPO_RX_PARITY_EN SHALL, when defined, add output port parity_err (1 bit), expect one even-parity bit after bit WIDTH-1 in state PARITY, complete the word on that bit's edge, and update parity_err together with dout (1 = mismatch; word still delivered; sticky until clr).
REQ-026 Without SIPO_RX_PARITY_EN, the parity_err port and PARITY state SHALL be absent and completion SHALL follow REQ-017.

Structure
REQ-027 Package sipo_rx_pkg SHALL hold the FSM state enum and the default WIDTH constant (16).
REQ-028 The block SHALL be a single module with no sub-module, because the FSM, counter and output register are tightly coupled.

Verification
REQ-029 Scenario: MSB_FIRST=1; send 0xA5C3 MSB first with bit_en=1 every cycle and sof on the first bit -> dout=0xA5C3 and dout_valid=1 on the 16th bit edge.
REQ-030 Scenario: MSB_FIRST=0; send 0x0001 with bit_en toggling 1/0 -> dout=0x0001 after 16 qualified bits, with state held on the idle cycles.
REQ-031 Scenario: two back-to-back words 0x1234 then 0xBEEF with dout_ready=0 -> dout=0x1234 and overrun=1; clr -> overrun=0.
REQ-032 Scenario: dout_ready=1 on the completion edge of the second word -> dout=0xBEEF, dout_valid stays 1 and overrun=0.
REQ-033 Scenario: sof reasserted after 7 bits, then a full 0x00FF sent -> dout=0x00FF and overrun=0; a separate run with rst_n pulsed after bit 5 -> no dout_valid.
REQ-034 Scenario (SIPO_RX_PARITY_EN): 0x0003 followed by parity bit 1 -> parity_err=1 and dout=0x0003; parity bit 0 -> parity_err=0.
